muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request a new operation; sampled on the rising edge.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  rs operand from the register file (dividend or multiplicand).
REQ-007 b  input  32  rt operand from the register file (divisor or multiplier).
REQ-008 hi_we  input  1  MTHI write enable.
REQ-009 lo_we  input  1  MTLO write enable.
REQ-010 wdata  input  32  MTHI/MTLO write data.
REQ-011 hi  output  32  HI register, feeding MFHI.
REQ-012 lo  output  32  LO register, feeding MFLO.
REQ-013 busy  output  1  high while an operation is in flight.
REQ-014 done  output  1  one-cycle pulse when a result lands in HI/LO.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and FIX.
REQ-016 In IDLE with start=1, the edge SHALL latch op, a and b, load the iteration counter with 32, and enter RUN; busy SHALL read 1 from that edge onward.
REQ-017 In RUN, each edge SHALL perform one iteration: one shift-add step for multiply or one restoring subtract-shift step for divide; the FSM SHALL move to FIX after the 32nd iteration.
REQ-018 In FIX, one edge SHALL apply the sign correction, write HI/LO, and return to IDLE; busy SHALL read 0 and done SHALL read 1 for exactly the cycle after that edge.
REQ-019 Latency SHALL be fixed at 34 edges from the accepting edge to the HI/LO update, independent of operand values.
REQ-020 Signed ops (MULT, DIV) SHALL iterate on magnitudes; MULT negates the 64-bit product if the sign of a differs from the sign of b.
REQ-021 DIV SHALL give the quotient the sign of a XOR the sign of b, and the remainder the sign of a.
REQ-022 MULT/MULTU SHALL write HI = product[63:32] and LO = product[31:0].
REQ-023 DIV/DIVU SHALL write LO = quotient and HI = remainder.
REQ-024 Divide by zero (b=0, DIV or DIVU) SHALL write LO = 32'hFFFFFFFF and HI = a; busy and latency SHALL be unchanged.
REQ-025 DIV overflow (a=32'h80000000, b=32'hFFFFFFFF) SHALL write LO = 32'h80000000 and HI = 0.
REQ-026 start while busy SHALL be ignored, with no queuing and no effect on the op in flight.
REQ-027 a, b and op changing after the accepting edge SHALL NOT affect the result.
REQ-028 In IDLE, hi_we SHALL load HI from wdata and lo_we SHALL load LO from wdata on the edge; asserting both SHALL load both.
REQ-029 hi_we and lo_we while busy SHALL be ignored.
REQ-030 start together with hi_we or lo_we in IDLE: start SHALL win and the write SHALL be dropped.
REQ-031 HI/LO SHALL hold their values at all times other than the FIX edge, an accepted write, or reset.

Reset
REQ-032 Asserting reset_n=0 SHALL immediately force the state to IDLE, hi=0, lo=0, busy=0 and done=0, regardless of clk.
REQ-033 Reset mid-operation SHALL abort the operation with no HI/LO update and no done pulse.
REQ-034 After release, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-035 MULTU a=32'hFFFFFFFF, b=2 -> after 34 edges hi=1, lo=32'hFFFFFFFE; done pulses exactly once; busy is high for 34 cycles.
REQ-036 MULT a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-037 DIV a=-7, b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU a=29, b=0 -> lo=32'hFFFFFFFF, hi=29.
REQ-038 DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
REQ-039 Mid-operation stimulus -> a second start, a changed a, and hi_we=1 with wdata=5 are all ignored; the first result is intact. The same stimulus in IDLE -> hi=5.
REQ-040 reset_n pulsed low at iteration 10 -> hi=lo=0 and busy=0 immediately; no done pulse; the next MULTU a=6, b=7 gives lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add or restoring-divide steps on
// operand magnitudes, followed by one sign-correction cycle that writes HI/LO.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t              state;
    logic [5:0]          cnt;

    logic                is_div_r;
    logic                neg_q_r;
    logic                neg_r_r;
    logic                div_zero_r;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W-1:0]   opnd;

    logic                accept;
    logic                step;
    logic                sgn_in;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_sh;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;

    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x,
                                              input logic sgn);
        logic signed [DATA_W-1:0] nx;
        nx = -x;
        return (sgn && x[DATA_W-1]) ? DATA_W'(nx) : DATA_W'(x);
    endfunction

    function automatic logic [DATA_W-1:0] cneg32(input logic [DATA_W-1:0] x, input logic n);
        return n ? (~x + DATA_W'(1)) : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] cneg64(input logic [2*DATA_W-1:0] x, input logic n);
        return n ? (~x + (2*DATA_W)'(1)) : x;
    endfunction

    assign accept = (state == IDLE) && start;
    assign step   = (state == RUN) && (cnt != 6'd0);
    assign sgn_in = ~op[0];

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
        div_sh   = {acc_hi, acc_lo[DATA_W-1]};
        div_ge   = div_sh >= {1'b0, opnd};
        div_diff = div_sh - {1'b0, opnd};
    end

    // Datapath: operand capture on accept, one iteration per RUN step.
    // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
    // divide shifts the dividend out of acc_lo and the quotient bits in at the bottom.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_r   <= op[1];
            neg_q_r    <= sgn_in && (a[DATA_W-1] ^ b[DATA_W-1]);
            neg_r_r    <= sgn_in && a[DATA_W-1];
            div_zero_r <= op[1] && (b == '0);
            a_r        <= a;
            acc_hi     <= '0;
            acc_lo     <= op[1] ? mag(a, sgn_in) : mag(b, sgn_in);
            opnd       <= op[1] ? mag(b, sgn_in) : mag(a, sgn_in);
        end else if (step) begin
            if (is_div_r) begin
                acc_hi <= div_ge ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0];
                acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
            end else begin
                acc_hi <= mul_sum[DATA_W:1];
                acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
            end
        end
    end

    // Control and architectural HI/LO. The RUN state spends one extra edge with the
    // counter at zero before FIX, giving a fixed 34-edge latency from accept to update.
    // The most-negative / -1 divide needs no special case: its magnitude quotient
    // 0x80000000 is left un-negated because both signs are negative.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= 6'd32;
                        busy  <= 1'b1;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    if (cnt == 6'd0) state <= FIX;
                    else             cnt   <= cnt - 6'd1;
                end
                FIX: begin
                    if (div_zero_r) begin
                        hi <= a_r;
                        lo <= '1;
                    end else if (is_div_r) begin
                        hi <= cneg32(acc_hi, neg_r_r);
                        lo <= cneg32(acc_lo, neg_q_r);
                    end else begin
                        {hi, lo} <= cneg64({acc_hi, acc_lo}, neg_q_r);
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int ncmp = 0;
    int nbad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of run, required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nbad++;
            $error("FAIL %s: observed %h required %h", tag, obs, expv);
        end
    endtask

    // Reference: {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint sp;
        int sq, sr;
        case (o)
            MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return sp;
            end
            MULTU: return {32'd0, x} * {32'd0, y};
            DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sq = $signed(x) / $signed(y);
                sr = $signed(x) % $signed(y);
                return {sr, sq};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit disturb, input bit wr_at_start, input string tag);
        logic [63:0] e;
        int n;
        int bcnt;
        bit seen;
        e = model(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (wr_at_start) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A_A5A5; end
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        chk({tag, ".busy_accept"}, 32'(busy), 32'd1);
        bcnt = 32'(busy);
        n = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            if (disturb && n == 5) begin
                start = 1'b1; a = ~x; b = y + 32'd3; hi_we = 1'b1; wdata = 32'd5;
            end else if (disturb && n == 6) begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
            else      bcnt += 32'(busy);
        end
        chk({tag, ".latency"}, 32'(n), 32'd34);
        chk({tag, ".busy_cycles"}, 32'(bcnt), 32'd34);
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, ".hi"}, hi, e[63:32]);
        chk({tag, ".lo"}, lo, e[31:0]);
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        @(posedge clk); #1;
        chk({tag, ".done_single"}, 32'(done), 32'd0);
        chk({tag, ".hi_hold"}, hi, exp_hi);
    endtask

    function automatic logic [31:0] pick(input bit allow_zero);
        case ($urandom_range(0, 5))
            0, 1: return $urandom;
            2:    return 32'($urandom_range(0, 200)) - 32'd100;
            3:    return 32'h8000_0000;
            4:    return 32'hFFFF_FFFF;
            default: return allow_zero ? 32'd0 : 32'd1;
        endcase
    endfunction

    initial begin
        int dcnt;
        logic [31:0] rx, ry;
        reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #1;
        chk("reset.hi", hi, 32'd0);
        chk("reset.lo", lo, 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // IDLE writes: separate, then together
        @(negedge clk); hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        @(negedge clk); lo_we = 1'b0; wdata = $urandom;
        @(negedge clk);
        chk("mthi.hi", hi, 32'h1234_5678);
        chk("mtlo.lo", lo, 32'h9ABC_DEF0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
        @(negedge clk);
        chk("both.hi", hi, 32'hCAFE_F00D);
        chk("both.lo", lo, 32'hCAFE_F00D);

        run_op(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, "multu_max");
        chk("multu_max.hi_const", exp_hi, 32'd1);
        run_op(MULT, -32'sd3, 32'd7, 1'b0, 1'b0, "mult_neg");
        run_op(DIV, -32'sd7, 32'd2, 1'b0, 1'b0, "div_neg");
        run_op(DIVU, 32'd29, 32'd0, 1'b0, 1'b0, "divu_zero");
        run_op(DIV, -32'sd5, 32'd0, 1'b0, 1'b0, "div_zero");
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
        run_op(MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "mult_minmin");
        run_op(MULTU, 32'd12345, 32'd678, 1'b1, 1'b0, "mid_ignore");

        // The same MTHI stimulus with the unit idle does take effect
        @(negedge clk); hi_we = 1'b1; wdata = 32'd5;
        @(negedge clk); hi_we = 1'b0;
        chk("idle_mthi.hi", hi, 32'd5);
        chk("idle_mthi.lo", lo, exp_lo);

        run_op(DIVU, 32'd1000, 32'd7, 1'b0, 1'b1, "start_wins");

        for (int i = 0; i < 16; i++) begin
            rx = pick(1'b0);
            ry = pick(1'b1);
            run_op(2'($urandom), rx, ry, 1'b0, 1'b0, "rand");
        end

        // Abort in flight with an asynchronous reset
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "pre_abort");
        @(negedge clk); start = 1'b1; op = MULTU; a = 32'd99; b = 32'd77;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            dcnt += 32'(done);
        end
        chk("abort.no_done", 32'(dcnt), 32'd0);
        chk("abort.hi_kept", hi, 32'd0);
        run_op(MULTU, 32'd6, 32'd7, 1'b0, 1'b0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
